// File: rtl/v_pipe_query_mp_pkg.sv
// v_pipe_query_mp_pkg: shared types, error codes and level decode/mux helpers for the query pipeline
package v_pipe_query_mp_pkg;
  localparam int QUERY_N_MAX = 8;
  localparam int LEVELS_N = 4;
  typedef logic [7:0] id_t;
  typedef id_t addr_t;
  typedef logic [1:0] level_t;
  typedef logic [LEVELS_N-1:0] level_dec_t;
  typedef logic [7:0] key_t;
  typedef logic [7:0] volume_t;
  typedef logic [3:0] listsize_t;
  typedef logic [$clog2(QUERY_N_MAX)-1:0] query_port_t;
  typedef enum logic [1:0] {QERR_OK = 2'd0, QERR_BUSY = 2'd1, QERR_INVALID = 2'd2} query_err_t;
  typedef struct packed {
    level_dec_t vld;
    key_t [LEVELS_N-1:0] key;
    volume_t [LEVELS_N-1:0] vol;
    listsize_t listsize;
  } state_t;
  typedef struct packed {
    id_t id;
    level_dec_t dec;
    query_err_t err;
  } entry_t;
  function automatic level_dec_t level_dec(level_t l);
    return level_dec_t'(1) << l;
  endfunction
  function automatic logic [7:0] lvl_mux(logic [LEVELS_N-1:0][7:0] a, level_dec_t d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < LEVELS_N; i++) r = r | (d[i] ? a[i] : 8'h00);
    return r;
  endfunction
  function automatic entry_t upd_chk(entry_t e, logic v, id_t id);
    entry_t r;
    r = e;
    r.err = (v && id == e.id) ? QERR_BUSY : e.err;
    return r;
  endfunction
endpackage

// File: rtl/v_pipe_query_mp_if.sv
// v_pipe_query_mp_if: per-port query requests and the shared response bus
interface v_pipe_query_mp_if import v_pipe_query_mp_pkg::*; #(parameter int QUERY_N = 2);
  logic [QUERY_N-1:0] i_q_vld;
  id_t [QUERY_N-1:0] i_q_prod_id;
  level_t [QUERY_N-1:0] i_q_level;
  logic [QUERY_N-1:0] o_q_rdy;
  logic [QUERY_N-1:0] o_rsp_vld_r;
  key_t o_rsp_key;
  volume_t o_rsp_size;
  listsize_t o_rsp_listsize;
  query_err_t o_rsp_err;
  modport master (output i_q_vld, i_q_prod_id, i_q_level,
                  input o_q_rdy, o_rsp_vld_r, o_rsp_key, o_rsp_size, o_rsp_listsize, o_rsp_err);
  modport slave (input i_q_vld, i_q_prod_id, i_q_level,
                 output o_q_rdy, o_rsp_vld_r, o_rsp_key, o_rsp_size, o_rsp_listsize, o_rsp_err);
endinterface

// File: rtl/v_pipe_query_mp_rr_arb.sv
// v_rr_arb: N-way round-robin arbiter over an eligibility mask with a flopped pointer
module v_rr_arb #(
  parameter int N = 2,
  localparam int PW = $clog2(N > 1 ? N : 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  logic [PW-1:0] ptr_q, ptr_d;
  int idx;
  // scan from farthest to nearest so the requester closest at/after the pointer wins
  always_comb begin
    gnt = '0;
    gnt_idx = ptr_q;
    ptr_d = ptr_q;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N;
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        gnt_idx = PW'(idx);
        ptr_d = PW'((idx + 1) % N);
      end
    end
  end
  // pointer advances past the winner, otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/v_pipe_query_mp.sv
// v_pipe_query_mp: multi-port arbitrated state-table query pipeline with busy-hazard tracking
module v_pipe_query_mp import v_pipe_query_mp_pkg::*; #(
  parameter int QUERY_N = 2,
  parameter int RD_LAT = 1,
  parameter int UPD_STAGES_N = 4,
  parameter int BUSY_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  v_pipe_query_mp_if.slave              q,
  output logic                          o_state_ren,
  output addr_t                         o_state_raddr,
  input  state_t                        i_state_rdata,
  input  logic [UPD_STAGES_N-1:0]       i_upd_vld_r,
  input  id_t [UPD_STAGES_N-1:0]        i_upd_prod_id_r
);
  localparam int PW = $clog2(QUERY_N > 1 ? QUERY_N : 2);
  logic [QUERY_N-1:0] hit, req, gnt;
  logic [PW-1:0] gnt_idx;
  logic [RD_LAT-1:0][QUERY_N-1:0] pv_d, pv_q;
  entry_t ent_d [RD_LAT];
  entry_t ent_q [RD_LAT];
  entry_t last;
  // per-port hit against the flopped update stages; hold-and-replay mode masks hit ports out
  always_comb begin
    hit = '0;
    for (int p = 0; p < QUERY_N; p++)
      for (int k = 0; k < UPD_STAGES_N; k++)
        hit[p] = hit[p] | (i_upd_vld_r[k] && i_upd_prod_id_r[k] == q.i_q_prod_id[p]);
    req = rst ? '0 : (BUSY_MODE != 0 ? q.i_q_vld & ~hit : q.i_q_vld);
  end
  v_rr_arb #(.N(QUERY_N)) u_arb (.clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_idx(gnt_idx));
  assign q.o_q_rdy = gnt;
  assign o_state_ren = |gnt;
  assign o_state_raddr = q.i_q_prod_id[gnt_idx];
  // new entry enters stage 1; every stage re-checks the youngest update so late updates still mark busy
  always_comb begin
    pv_d[0] = gnt;
    ent_d[0] = '{id: o_state_raddr, dec: level_dec(q.i_q_level[gnt_idx]), err: hit[gnt_idx] ? QERR_BUSY : QERR_OK};
    for (int s = 1; s < RD_LAT; s++) begin
      pv_d[s] = pv_q[s-1];
      ent_d[s] = upd_chk(ent_q[s-1], i_upd_vld_r[0], i_upd_prod_id_r[0]);
    end
    last = upd_chk(ent_q[RD_LAT-1], i_upd_vld_r[0], i_upd_prod_id_r[0]);
  end
  // one-hot port valids per stage; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pv_q <= '0;
    else pv_q <= pv_d;
  end
  // entry payload travels alongside the valids without reset
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end
  assign q.o_rsp_vld_r = pv_q[RD_LAT-1];
  assign q.o_rsp_key = lvl_mux(i_state_rdata.key, last.dec);
  assign q.o_rsp_size = lvl_mux(i_state_rdata.vol, last.dec);
  assign q.o_rsp_listsize = i_state_rdata.listsize;
  assign q.o_rsp_err = last.err == QERR_BUSY ? QERR_BUSY :
                       ((last.dec & i_state_rdata.vld) == '0 ? QERR_INVALID : QERR_OK);
endmodule

// File: tb/tb_v_pipe_query_mp.sv
// tb_v_pipe_query_mp: two configurations driven with random traffic against a queue-level reference
module tb_v_pipe_query_mp;
  import v_pipe_query_mp_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rnd = 1'b0;
  logic [2:0] vld [2];
  id_t [2:0] pid [2];
  level_t [2:0] lvl [2];
  logic [2:0] rdy [2];
  logic [2:0] rvld [2];
  key_t key [2];
  volume_t vol [2];
  listsize_t ls [2];
  query_err_t err [2];
  logic ren [2];
  addr_t raddr [2];
  state_t rdata [2];
  logic [3:0] upd_vld;
  id_t [3:0] upd_id;
  state_t mem [256];
  addr_t rd_line [2][3];
  logic cap_ren [2];
  addr_t cap_addr [2];
  typedef struct {bit v; int port; id_t id; level_t lv; bit busy;} exp_t;
  exp_t slot [2][4];
  int ptr [2];
  logic [2:0] gnt_m [2];

  v_pipe_query_mp_if #(.QUERY_N(2)) if0 ();
  v_pipe_query_mp_if #(.QUERY_N(3)) if1 ();
  assign if0.i_q_vld = vld[0][1:0];
  assign if0.i_q_prod_id = pid[0][1:0];
  assign if0.i_q_level = lvl[0][1:0];
  assign rdy[0] = {1'b0, if0.o_q_rdy};
  assign rvld[0] = {1'b0, if0.o_rsp_vld_r};
  assign key[0] = if0.o_rsp_key;
  assign vol[0] = if0.o_rsp_size;
  assign ls[0] = if0.o_rsp_listsize;
  assign err[0] = if0.o_rsp_err;
  assign if1.i_q_vld = vld[1];
  assign if1.i_q_prod_id = pid[1];
  assign if1.i_q_level = lvl[1];
  assign rdy[1] = if1.o_q_rdy;
  assign rvld[1] = if1.o_rsp_vld_r;
  assign key[1] = if1.o_rsp_key;
  assign vol[1] = if1.o_rsp_size;
  assign ls[1] = if1.o_rsp_listsize;
  assign err[1] = if1.o_rsp_err;

  v_pipe_query_mp #(.QUERY_N(2), .RD_LAT(1), .UPD_STAGES_N(4), .BUSY_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .q(if0.slave), .o_state_ren(ren[0]), .o_state_raddr(raddr[0]),
    .i_state_rdata(rdata[0]), .i_upd_vld_r(upd_vld), .i_upd_prod_id_r(upd_id));
  v_pipe_query_mp #(.QUERY_N(3), .RD_LAT(3), .UPD_STAGES_N(4), .BUSY_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .q(if1.slave), .o_state_ren(ren[1]), .o_state_raddr(raddr[1]),
    .i_state_rdata(rdata[1]), .i_upd_vld_r(upd_vld), .i_upd_prod_id_r(upd_id));

  function automatic int qn(int i); return i == 0 ? 2 : 3; endfunction
  function automatic int rl(int i); return i == 0 ? 1 : 3; endfunction
  function automatic int bm(int i); return i == 0 ? 0 : 1; endfunction

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  // reference for one cycle of instance i, evaluated on settled inputs
  task automatic model(int i);
    int w;
    logic [2:0] hit, el;
    exp_t e;
    state_t s;
    w = -1;
    hit = '0;
    el = '0;
    cap_ren[i] = ren[i];
    cap_addr[i] = raddr[i];
    if (rst) begin
      for (int k = 0; k < 4; k++) slot[i][k].v = 1'b0;
      ptr[i] = 0;
      gnt_m[i] = '0;
      check($sformatf("i%0d rst_rdy", i), rdy[i], 0);
      check($sformatf("i%0d rst_ren", i), ren[i], 0);
      check($sformatf("i%0d rst_rvld", i), rvld[i], 0);
      return;
    end
    for (int k = 0; k < 4; k++)
      if (slot[i][k].v && upd_vld[0] && upd_id[0] == slot[i][k].id) slot[i][k].busy = 1'b1;
    e = slot[i][cyc % 4];
    slot[i][cyc % 4].v = 1'b0;
    check($sformatf("i%0d rvld", i), rvld[i], e.v ? 3'b001 << e.port : 3'b000);
    if (e.v) begin
      s = mem[e.id];
      check($sformatf("i%0d key", i), key[i], s.key[e.lv]);
      check($sformatf("i%0d vol", i), vol[i], s.vol[e.lv]);
      check($sformatf("i%0d lsize", i), ls[i], s.listsize);
      check($sformatf("i%0d err", i), err[i], e.busy ? QERR_BUSY : (s.vld[e.lv] ? QERR_OK : QERR_INVALID));
    end
    for (int p = 0; p < qn(i); p++) begin
      for (int k = 0; k < 4; k++) if (upd_vld[k] && upd_id[k] == pid[i][p]) hit[p] = 1'b1;
      el[p] = vld[i][p] && !(bm(i) == 1 && hit[p]);
    end
    for (int o = 0; o < qn(i); o++) begin
      int c;
      c = (ptr[i] + o) % qn(i);
      if (el[c]) begin
        w = c;
        break;
      end
    end
    gnt_m[i] = w < 0 ? 3'b000 : 3'b001 << w;
    check($sformatf("i%0d rdy", i), rdy[i], gnt_m[i]);
    check($sformatf("i%0d ren", i), ren[i], w >= 0);
    if (w >= 0) begin
      check($sformatf("i%0d raddr", i), raddr[i], pid[i][w]);
      slot[i][(cyc + rl(i)) % 4] = '{1'b1, w, pid[i][w], lvl[i][w], bm(i) == 0 && hit[w]};
      ptr[i] = (w + 1) % qn(i);
    end
  endtask

  // one clock: check at negedge, then advance RAM, requesters and update stages after the edge
  task automatic step();
    @(negedge clk);
    model(0);
    model(1);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      for (int d = 2; d > 0; d--) rd_line[i][d] = rd_line[i][d-1];
      rd_line[i][0] = cap_ren[i] ? cap_addr[i] : 8'($urandom);
      rdata[i] = mem[rd_line[i][rl(i)-1]];
      if (rnd)
        for (int p = 0; p < qn(i); p++)
          if (!vld[i][p] || gnt_m[i][p]) begin
            vld[i][p] = $urandom_range(0, 9) < 7;
            pid[i][p] = 8'($urandom_range(0, 7));
            lvl[i][p] = 2'($urandom);
          end
    end
    if (rnd) begin
      upd_vld = {upd_vld[2:0], $urandom_range(0, 3) == 0};
      upd_id = {upd_id[2:0], 8'($urandom_range(0, 7))};
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a].vld = 4'($urandom);
      mem[a].key = 32'($urandom);
      mem[a].vol = 32'($urandom);
      mem[a].listsize = 4'($urandom);
    end
    mem[5].vld[2] = 1'b1;
    mem[5].key[2] = 8'h3A;
    mem[5].vol[2] = 8'd7;
    mem[5].listsize = 4'd3;
    for (int i = 0; i < 2; i++) begin
      vld[i] = '0;
      pid[i] = '0;
      lvl[i] = '0;
      rdata[i] = '0;
      ptr[i] = 0;
      gnt_m[i] = '0;
      for (int d = 0; d < 3; d++) rd_line[i][d] = '0;
      for (int k = 0; k < 4; k++) slot[i][k] = '{1'b0, 0, 8'h00, 2'd0, 1'b0};
    end
    upd_vld = '0;
    upd_id = '0;
    step();
    step();
    rst = 1'b0;
    vld[0][0] = 1'b1;
    pid[0][0] = 8'd5;
    lvl[0][0] = 2'd2;
    step();
    vld[0][0] = 1'b0;
    #1;
    check("t1_rvld", rvld[0], 3'b001);
    check("t1_key", key[0], 8'h3A);
    check("t1_size", vol[0], 8'd7);
    check("t1_lsize", ls[0], 4'd3);
    check("t1_err", err[0], QERR_OK);
    step();
    rnd = 1'b1;
    for (int n = 0; n < 1500; n++) step();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) step();
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) step();
    rnd = 1'b0;
    vld[0] = '0;
    vld[1] = '0;
    for (int n = 0; n < 6; n++) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/v_pipe_query_mp.md
Name: v_pipe_query_mp

Overview:
- Multi-port, parametrised successor to the single-port list query pipeline.
- QUERY_N independent query ports are round-robin arbitrated onto one state-table read port.
- RAM read latency and update-pipeline depth are parameters.
- Busy hazards are handled in one of two modes: error-out or hold-and-replay. Responses carry a 2-bit error code and return on a shared bus with a one-hot per-port valid.

Parameters:
- QUERY_N, 2, number of query ports (1..8).
- RD_LAT, 1, state RAM read latency in cycles (1..3).
- UPD_STAGES_N, 4, number of update-pipeline stages checked for hazards.
- BUSY_MODE, 0, 0 = busy hit returns ERR_BUSY; 1 = busy hit is not granted and is replayed.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_q_vld  in  QUERY_N  per-port query request valid.
- i_q_prod_id  in  QUERY_N x id_t  per-port product ID.
- i_q_level  in  QUERY_N x level_t  per-port level.
- o_q_rdy  out  QUERY_N  per-port accept (combinational).
- o_rsp_vld_r  out  QUERY_N  one-hot response valid (flopped).
- o_rsp_key  out  key_t  response key.
- o_rsp_size  out  volume_t  response volume.
- o_rsp_listsize  out  listsize_t  response list size.
- o_rsp_err  out  query_err_t  OK / BUSY / INVALID.
- o_state_ren  out  1  state RAM read enable.
- o_state_raddr  out  addr_t  state RAM read address.
- i_state_rdata  in  state_t  RAM data, valid RD_LAT cycles after ren.
- i_upd_vld_r  in  UPD_STAGES_N  update pipeline stage valids; index 0 is the youngest stage.
- i_upd_prod_id_r  in  UPD_STAGES_N x id_t  update stage IDs.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: all pipeline valids = 0; o_rsp_vld_r = 0; arbiter pointer = port 0; o_state_ren = 0 and o_q_rdy = 0 while rst is high. Data flops are not reset.
- Handshake:
  - A request transfers when i_q_vld[p] & o_q_rdy[p].
  - A requester holds vld, id and level stable until accepted.
  - At most one port is granted per cycle.
  - o_q_rdy is one-hot or zero.
- Arbitration: round-robin among eligible ports, starting at the pointer. On grant of port p, the pointer moves to p+1 mod QUERY_N. With no grant, the pointer is unchanged.
- S0 hazard: hit = any i_upd_vld_r[k] with i_upd_prod_id_r[k] == the port's id.
  - BUSY_MODE=0: all valid ports are eligible; a hit sets the carried err to BUSY.
  - BUSY_MODE=1: a port with a hit is ineligible (o_q_rdy low) and other ports may be granted. It is granted automatically once the hazard clears.
- Issue: on grant, o_state_ren = 1 and o_state_raddr = granted id, in the same cycle. A pipeline entry {port, id, level-decoded, err} enters stage 1.
- Pipeline: an RD_LAT-deep shift register. In each stage, if i_upd_vld_r[0] and i_upd_prod_id_r[0] == the stage id, err is set to BUSY in both modes. This catches updates entering after the lookup.
- Response stage (RD_LAT cycles after issue):
  - key and volume are muxed from i_state_rdata using the decoded level.
  - listsize is taken from i_state_rdata.listsize.
  - INVALID if (level_dec & rdata.vld) == 0.
  - Error priority: BUSY > INVALID > OK.
  - Response outputs are combinational off rdata.
  - o_rsp_vld_r[port] = 1 for exactly one cycle.
- Throughput and latency: one query per cycle, sustained, with no bubbles. Latency from acceptance to o_rsp_vld_r is RD_LAT cycles.
- Ordering: responses return in grant order. A port may have multiple queries in flight.
- Reset mid-operation: all in-flight entries are discarded and no response is produced. Queries must be reissued after reset.
- Simultaneous events: a hazard check and an update entering in the same cycle use the flopped update stages only. A query and an update to the same id in the same cycle are caught by the per-stage stage-0 check in the following cycle.

Decomposition:
- v_pkg additions:
  - query_err_t enum {QERR_OK=0, QERR_BUSY=1, QERR_INVALID=2}.
  - QUERY_N_MAX.
  - query_port_t (clog2 port index).
- Existing dec and mux instances are reused.
- One sub-module: v_rr_arb (parametrised N-way round-robin arbiter with eligibility mask, pointer flop, async reset).

Test Plan:
1. QUERY_N=2, RD_LAT=1. Port0 queries id 5 level 2; the entry holds key 0x3A, vol 7, listsize 3. Expected: o_rsp_vld_r=2'b01 one cycle later, key 0x3A, size 7, listsize 3, err OK.
2. Both ports request continuously for 4 cycles. Expected: grants alternate 0,1,0,1, with responses in the same order and no idle cycles.
3. BUSY_MODE=0. Port0 queries id 9 while i_upd_vld_r[2] holds id 9. Expected: err BUSY. With BUSY_MODE=1, the same stimulus holds o_q_rdy[0]=0 and port1 (id 4) is granted; port0 is granted the cycle after the stage clears and returns OK.
4. RD_LAT=3. Query id 7 is issued; an update for id 7 appears at stage 0 two cycles later. Expected: response err BUSY at cycle 3.
5. Query a level whose vld bit is 0. Expected: err INVALID. If busy as well, err BUSY.
6. Assert rst with 2 queries in flight (RD_LAT=2). Expected: no o_rsp_vld_r pulses, the pointer returns to 0, and a post-reset query completes normally.
